alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one `alu` instance between two requesters: requester 0 is the main execute path and requester 1 is the branch/address helper. Round-robin arbitration with valid/ready handshakes on every port. The granted request's operands drive the ALU combinationally, and the result and Zero flag are captured into a one-entry response register. The response is tagged with the requester ID and held until the consumer accepts it.

## Interface
- `DATA_WIDTH`, default 32: operand and result width; passed to the `alu` instance.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Req0Valid` / `Req1Valid` input 1: the requester presents an operation.
- `Req0Ready` / `Req1Ready` output 1: the arbiter accepts this cycle.
- `Req0SrcA`, `Req0SrcB` / `Req1SrcA`, `Req1SrcB` input DATA_WIDTH: operands.
- `Req0Op` / `Req1Op` input 3: ALUControl encoding.
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 pass B
  - 101 xor
  - 110 sll
  - 111 srl
- `RspValid` output 1: the response register holds a result.
- `RspReady` input 1: the consumer accepts the response.
- `RspId` output 1: the requester that issued the held result.
- `RspResult` output DATA_WIDTH: the ALU result.
- `RspZero` output 1: 1 when SrcA == SrcB for the issued operation.

## Operation
- Response register state:
  - EMPTY (`RspValid`=0) and FULL (`RspValid`=1).
  - `slot_free` = !RspValid || RspReady.
- Grant rules:
  - Only one valid requester: it is the candidate.
  - Both valid: the candidate is the requester not equal to `last_grant`.
  - `ReqNReady` = candidate==N && ReqNValid && slot_free && !rst. At most one ready is high per cycle.
- Transfer: occurs when ReqNValid && ReqNReady. On that edge:
  - `RspResult` and `RspZero` are loaded from the ALU, which is driven by requester N's operands.
  - `RspId` is loaded with N.
  - `RspValid` is set to 1.
  - `last_grant` is set to N.
- Drain:
  - RspValid && RspReady with no new transfer: `RspValid` goes to 0 and the other response fields hold.
  - Drain and transfer in the same cycle: the new result overwrites; `RspValid` stays 1.
- FULL with RspReady=0: both readies are 0 and the response fields are stable.
- Requesters must hold valid and operands until accepted. The arbiter ignores operand changes while not ready.
- Arithmetic: all ALU operations are modulo 2^DATA_WIDTH. Shift behaviour for amounts ≥ DATA_WIDTH is whatever `alu` produces; the arbiter does not alter it.
- Reset values:
  - `RspValid`=0, `RspId`=0, `RspResult`=0, `RspZero`=0.
  - `last_grant`=1, so requester 0 wins the first contention.
  - Readies are 0 while `rst` is high.
- Reset mid-operation: a held response is discarded. Requesters must re-present any transfer not completed before reset.

## Timing
- Latency: transfer on edge N puts the result on `RspValid` in cycle N+1, one register stage.
- Throughput: one operation per cycle while `RspReady` is held at 1, alternating between requesters under contention.
- Readies depend combinationally on ReqNValid, `RspValid`, `RspReady` and `last_grant`. A requester's valid must not depend on its ready.
- There is no combinational path from Req operands to any Rsp output.

## Configuration
- Macro: `ALU_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority. Requester 0 always wins contention and `last_grant` is not implemented.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Structure
- Shared package `alu_pkg` holds:
  - The `alu_op_t` 3-bit enum: ADD, SUB, AND, OR, PASSB, XOR, SLL, SRL.
  - The `REQ_ID_W`=1 constant.
  - The response-state enum {RSP_EMPTY, RSP_FULL}.
- One sub-module: the existing `alu`, instantiated once. Its inputs are muxed from the granted requester; its Zero and ALUResult outputs feed the response register.

## Test plan
- **Reset:** hold `rst` for 2 cycles with both Valids at 1 → both Readies 0; after release `RspValid`=0 and `RspResult`=0; the first grant goes to requester 0.
- **Single requester:** Req0 sub with A=5, B=5, RspReady=1 → next cycle `RspResult`=0, `RspZero`=1, `RspId`=0.
- **Contention, round-robin:** both requesters valid for 4 cycles. Req0 is add 1+2; Req1 is xor 0xF0^0x0F. Expected:
  - grants alternate 0,1,0,1;
  - `RspResult` alternates 3 / 0xFF;
  - `RspZero`=0.
- **Backpressure:** RspReady=0 after the first result 0x10 → both Readies stay 0 and `RspResult` holds 0x10 for 3 cycles. Raising RspReady drains it and accepts the next request in the same cycle.
- **Reset mid-operation:** assert `rst` while FULL with RspReady=0 → next cycle `RspValid`=0 and no response is emitted for the discarded op.
- **Fixed priority:** with `ALU_ARB_FIXED_PRIO_EN` defined and both valid for 3 cycles → all three grants go to requester 0 and Req1Ready stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU, the arbiter interface and the
// arbiter top.
//   alu_op_t    : 3-bit ALUControl encoding
//   REQ_ID_W    : width of the requester tag carried with each response
//   rsp_state_t : occupancy of the one-entry response register
package alu_pkg;

  typedef enum logic [2:0] {
    ADD   = 3'b000,
    SUB   = 3'b001,
    AND   = 3'b010,
    OR    = 3'b011,
    PASSB = 3'b100,
    XOR   = 3'b101,
    SLL   = 3'b110,
    SRL   = 3'b111
  } alu_op_t;

  localparam int REQ_ID_W = 1;

  typedef enum logic {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: bundle of the two request ports and the response port of
// alu_arbiter.
//   master : the requester/consumer side (drives valids, operands, RspReady)
//   slave  : the arbiter side (drives readies and the response fields)
// Parameter DATA_WIDTH must match the arbiter's DATA_WIDTH.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) ();

  logic                  Req0Valid;
  logic                  Req0Ready;
  logic [DATA_WIDTH-1:0] Req0SrcA;
  logic [DATA_WIDTH-1:0] Req0SrcB;
  logic [2:0]            Req0Op;

  logic                  Req1Valid;
  logic                  Req1Ready;
  logic [DATA_WIDTH-1:0] Req1SrcA;
  logic [DATA_WIDTH-1:0] Req1SrcB;
  logic [2:0]            Req1Op;

  logic                  RspValid;
  logic                  RspReady;
  logic [REQ_ID_W-1:0]   RspId;
  logic [DATA_WIDTH-1:0] RspResult;
  logic                  RspZero;

  modport master (
    output Req0Valid, Req0SrcA, Req0SrcB, Req0Op,
    output Req1Valid, Req1SrcA, Req1SrcB, Req1Op,
    output RspReady,
    input  Req0Ready, Req1Ready,
    input  RspValid, RspId, RspResult, RspZero
  );

  modport slave (
    input  Req0Valid, Req0SrcA, Req0SrcB, Req0Op,
    input  Req1Valid, Req1SrcA, Req1SrcB, Req1Op,
    input  RspReady,
    output Req0Ready, Req1Ready,
    output RspValid, RspId, RspResult, RspZero
  );

endinterface

// File: rtl/alu.sv
// alu: purely combinational ALU.
//   SrcA, SrcB  : operands (DATA_WIDTH)
//   ALUControl  : operation, alu_op_t encoding
//   ALUResult   : result, modulo 2^DATA_WIDTH
//   Zero        : 1 when SrcA == SrcB
// Shifts use the full SrcB value, so amounts >= DATA_WIDTH yield 0.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic [2:0]            ALUControl,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero
);

  always_comb begin
    ALUResult = '0;
    case (alu_op_t'(ALUControl))
      ADD:     ALUResult = SrcA + SrcB;
      SUB:     ALUResult = SrcA - SrcB;
      AND:     ALUResult = SrcA & SrcB;
      OR:      ALUResult = SrcA | SrcB;
      PASSB:   ALUResult = SrcB;
      XOR:     ALUResult = SrcA ^ SrcB;
      SLL:     ALUResult = SrcA << SrcB;
      SRL:     ALUResult = SrcA >> SrcB;
      default: ALUResult = '0;
    endcase
  end

  // Zero reports operand equality, which is what branch compares need.
  assign Zero = (SrcA == SrcB);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters (0 = execute path,
// 1 = branch/address helper) and captures the result into a one-entry,
// requester-tagged response register.
//   clk, rst : clock and synchronous active-high reset
//   bus      : alu_arbiter_if.slave (request ports 0/1, response port)
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// always wins contention, no last_grant state); default is round-robin.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus
);

  rsp_state_t            state_reg, state_next;
  logic [REQ_ID_W-1:0]   rsp_id_reg;
  logic [DATA_WIDTH-1:0] rsp_result_reg;
  logic                  rsp_zero_reg;

  logic                  slot_free;
  logic                  cand;
  logic                  grant0, grant1;
  logic                  xfer;
  logic [REQ_ID_W-1:0]   xfer_id;

  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [2:0]            alu_op;
  logic                  alu_zero;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                  last_grant_reg;
`endif

  // Candidate selection. Under contention the round-robin build favours the
  // requester that did not win last time.
  always_comb begin
    cand = 1'b0;
    if (bus.Req0Valid && bus.Req1Valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      cand = 1'b0;
`else
      cand = ~last_grant_reg;
`endif
    end else begin
      cand = !bus.Req0Valid;
    end
  end

  always_comb begin
    slot_free = (state_reg == RSP_EMPTY) || bus.RspReady;
    grant0    = !cand && bus.Req0Valid && slot_free && !rst;
    grant1    =  cand && bus.Req1Valid && slot_free && !rst;
    xfer      = grant0 || grant1;
    xfer_id   = grant1;
  end

  // The ALU is fed from the candidate; its output only matters on a transfer,
  // and the candidate is exactly the granted requester whenever one exists.
  always_comb begin
    if (cand) begin
      alu_a  = bus.Req1SrcA;
      alu_b  = bus.Req1SrcB;
      alu_op = bus.Req1Op;
    end else begin
      alu_a  = bus.Req0SrcA;
      alu_b  = bus.Req0SrcB;
      alu_op = bus.Req0Op;
    end
  end

  alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .SrcA       (alu_a),
    .SrcB       (alu_b),
    .ALUControl (alu_op),
    .ALUResult  (alu_result),
    .Zero       (alu_zero)
  );

  // Response-state FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RSP_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Response-state FSM: next state. A transfer always leaves the slot full,
  // including when it coincides with a drain.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RSP_EMPTY: begin
        if (xfer) state_next = RSP_FULL;
      end
      RSP_FULL: begin
        if (xfer)              state_next = RSP_FULL;
        else if (bus.RspReady) state_next = RSP_EMPTY;
      end
      default: state_next = RSP_EMPTY;
    endcase
  end

  // Response-state FSM: outputs.
  always_comb begin
    bus.RspValid  = (state_reg == RSP_FULL);
    bus.Req0Ready = grant0;
    bus.Req1Ready = grant1;
  end

  // Payload register: loads only on a transfer, so a drain leaves the last
  // result visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id_reg     <= '0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
    end else if (xfer) begin
      rsp_id_reg     <= xfer_id;
      rsp_result_reg <= alu_result;
      rsp_zero_reg   <= alu_zero;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (xfer) begin
      last_grant_reg <= xfer_id;
    end
  end
`endif

  assign bus.RspId     = rsp_id_reg;
  assign bus.RspResult = rsp_result_reg;
  assign bus.RspZero   = rsp_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter. Directed vector table,
// hand-written multi-cycle sequences (reset, contention, backpressure, reset
// while full) and a randomized phase checked against a behavioural model.
// Honours ALU_ARB_FIXED_PRIO_EN when the build defines it.
module tb_alu_arbiter;

  localparam int W = 32;

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_PB  = 3'd4, OP_XOR = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_WIDTH(W)) bus ();

  alu_arbiter #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic v1, input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input logic rr);
    bus.Req0Valid = v0; bus.Req0Op = op0; bus.Req0SrcA = a0; bus.Req0SrcB = b0;
    bus.Req1Valid = v1; bus.Req1Op = op1; bus.Req1SrcA = a1; bus.Req1SrcB = b1;
    bus.RspReady  = rr;
  endtask

  // Reference ALU: {zero, result}. Shift amounts are kept below W by the bench.
  function automatic logic [32:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_PB:   r = b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    return {(a == b), r};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[12];

  // Behavioural model state for the random phase.
  logic        m_valid, m_zero, m_id, m_last;
  logic [31:0] m_res;
  logic        rv[2];
  logic [2:0]  rop[2];
  logic [31:0] ra[2], rb[2];

  initial begin
    vecs[0]  = '{OP_SUB, 32'd5,          32'd5,          32'd0,          1'b1};
    vecs[1]  = '{OP_ADD, 32'd1,          32'd2,          32'd3,          1'b0};
    vecs[2]  = '{OP_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[3]  = '{OP_SUB, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{OP_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0};
    vecs[5]  = '{OP_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
    vecs[6]  = '{OP_PB,  32'd7,          32'h0000_1234,  32'h0000_1234,  1'b0};
    vecs[7]  = '{OP_XOR, 32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0};
    vecs[8]  = '{OP_SLL, 32'd1,          32'd4,          32'h0000_0010,  1'b0};
    vecs[9]  = '{OP_SRL, 32'h8000_0000,  32'd31,         32'd1,          1'b0};
    vecs[10] = '{OP_XOR, 32'h1234_5678,  32'h1234_5678,  32'd0,          1'b1};
    vecs[11] = '{OP_AND, 32'hDEAD_BEEF,  32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b1};

    // ---- Reset with both requesters valid ----
    rst = 1'b1;
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b1, OP_XOR, 32'hF0, 32'h0F, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_req0ready", 32'(bus.Req0Ready), 32'd0);
      check("rst_req1ready", 32'(bus.Req1Ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("post_rst_rspvalid", 32'(bus.RspValid), 32'd0);
    check("post_rst_rspresult", bus.RspResult, 32'd0);

    // ---- Contention: add 1+2 vs xor F0^0F, four grants ----
    for (int i = 0; i < 4; i++) begin
      int g;
      g = FIXED ? 0 : (i % 2);
      #1;
      check($sformatf("cont%0d_req0ready", i), 32'(bus.Req0Ready), 32'(g == 0));
      check($sformatf("cont%0d_req1ready", i), 32'(bus.Req1Ready), 32'(g == 1));
      tick();
      $display("contention %0d: id=%0d result=%0h", i, bus.RspId, bus.RspResult);
      check($sformatf("cont%0d_rspvalid", i), 32'(bus.RspValid), 32'd1);
      check($sformatf("cont%0d_rspid", i), 32'(bus.RspId), 32'(g));
      check($sformatf("cont%0d_rspresult", i), bus.RspResult, (g == 0) ? 32'd3 : 32'hFF);
      check($sformatf("cont%0d_rspzero", i), 32'(bus.RspZero), 32'd0);
    end

    // ---- Directed vector table, alternating single requesters ----
    for (int i = 0; i < 12; i++) begin
      int n;
      n = i % 2;
      if (n == 0) drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
      else        drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
      #1;
      check($sformatf("vec%0d_ready", i), 32'(n == 0 ? bus.Req0Ready : bus.Req1Ready), 32'd1);
      tick();
      $display("vector %0d: req%0d op=%0d result=%0h zero=%0d", i, n, vecs[i].op, bus.RspResult, bus.RspZero);
      check($sformatf("vec%0d_rspvalid", i), 32'(bus.RspValid), 32'd1);
      check($sformatf("vec%0d_rspid", i), 32'(bus.RspId), 32'(n));
      check($sformatf("vec%0d_rspresult", i), bus.RspResult, vecs[i].res);
      check($sformatf("vec%0d_rspzero", i), 32'(bus.RspZero), 32'(vecs[i].zero));
    end

    // ---- Drain with no new request ----
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
    tick();
    check("drain_rspvalid", 32'(bus.RspValid), 32'd0);
    check("drain_hold_result", bus.RspResult, vecs[11].res);

    // ---- Backpressure ----
    drive(1'b1, OP_SLL, 32'd1, 32'd4, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
    #1;
    check("bp_first_ready", 32'(bus.Req0Ready), 32'd1);
    tick();
    drive(1'b1, OP_ADD, 32'h30, 32'd0, 1'b1, OP_ADD, 32'h20, 32'd1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("backpressure %0d: result=%0h", k, bus.RspResult);
      check($sformatf("bp%0d_req0ready", k), 32'(bus.Req0Ready), 32'd0);
      check($sformatf("bp%0d_req1ready", k), 32'(bus.Req1Ready), 32'd0);
      check($sformatf("bp%0d_rspvalid", k), 32'(bus.RspValid), 32'd1);
      check($sformatf("bp%0d_rspresult", k), bus.RspResult, 32'h10);
      tick();
    end
    bus.RspReady = 1'b1;
    #1;
    check("bp_release_req0ready", 32'(bus.Req0Ready), 32'(FIXED));
    check("bp_release_req1ready", 32'(bus.Req1Ready), 32'(!FIXED));
    tick();
    check("bp_next_rspvalid", 32'(bus.RspValid), 32'd1);
    check("bp_next_rspid", 32'(bus.RspId), 32'(!FIXED));
    check("bp_next_rspresult", bus.RspResult, FIXED ? 32'h30 : 32'h21);

    // ---- Reset while FULL and stalled ----
    drive(1'b1, OP_ADD, 32'd9, 32'd9, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_req0ready", 32'(bus.Req0Ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, OP_ADD, 32'd0, 32'd0, 1'b0, OP_ADD, 32'd0, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("midrst%0d_rspvalid", k), 32'(bus.RspValid), 32'd0);
      check($sformatf("midrst%0d_rspresult", k), bus.RspResult, 32'd0);
      tick();
    end

    // ---- Randomized phase against the behavioural model ----
    m_valid = 1'b0; m_zero = 1'b0; m_id = 1'b0; m_res = '0; m_last = 1'b1;
    for (int n = 0; n < 2; n++) begin
      rv[n] = 1'b0; rop[n] = '0; ra[n] = '0; rb[n] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      logic slot, e0, e1, rr;
      int cand;
      logic [32:0] r;
      for (int n = 0; n < 2; n++) begin
        if (!rv[n] && $urandom_range(0, 9) < 6) begin
          rv[n]  = 1'b1;
          rop[n] = 3'($urandom_range(0, 7));
          ra[n]  = $urandom;
          if (rop[n] == OP_SLL || rop[n] == OP_SRL) rb[n] = $urandom_range(0, 31);
          else if ($urandom_range(0, 3) == 0)       rb[n] = ra[n];
          else                                      rb[n] = $urandom;
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      drive(rv[0], rop[0], ra[0], rb[0], rv[1], rop[1], ra[1], rb[1], rr);
      #1;
      check("rnd_rspvalid", 32'(bus.RspValid), 32'(m_valid));
      check("rnd_rspid", 32'(bus.RspId), 32'(m_id));
      check("rnd_rspresult", bus.RspResult, m_res);
      check("rnd_rspzero", 32'(bus.RspZero), 32'(m_zero));
      slot = !m_valid || rr;
      if (rv[0] && rv[1]) cand = FIXED ? 0 : (m_last ? 0 : 1);
      else                cand = rv[0] ? 0 : 1;
      e0 = slot && rv[0] && (cand == 0);
      e1 = slot && rv[1] && (cand == 1);
      check("rnd_req0ready", 32'(bus.Req0Ready), 32'(e0));
      check("rnd_req1ready", 32'(bus.Req1Ready), 32'(e1));
      if (e0 || e1) begin
        int g;
        g = e1 ? 1 : 0;
        r = ref_alu(rop[g], ra[g], rb[g]);
        m_zero  = r[32];
        m_res   = r[31:0];
        m_id    = 1'(g);
        m_valid = 1'b1;
        m_last  = 1'(g);
        rv[g]   = 1'b0;
        $display("random %0d: req%0d op=%0d expect result=%0h zero=%0d", c, g, rop[g], m_res, m_zero);
      end else if (m_valid && rr) begin
        m_valid = 1'b0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
